// File: rtl/ysyx_040066_axi_pkg.sv
// Shared encodings for the io_slave AXI4 responder: response and burst codes,
// responder states and the 64-bit data/strobe widths.
package ysyx_040066_axi_pkg;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_MEM,
        RD_CAP,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;
endpackage

// File: rtl/ysyx_040066_axi_slave_if.sv
// AXI4 bus between the core's io_slave port (master) and the scratch-RAM
// responder (slave); 64-bit data, 4-bit IDs.
interface ysyx_040066_axi_slave_if;
    import ysyx_040066_axi_pkg::*;

    logic              awready;
    logic              awvalid;
    logic [31:0]       awaddr;
    logic [3:0]        awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              wready;
    logic              wvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              bready;
    logic              bvalid;
    logic [1:0]        bresp;
    logic [3:0]        bid;
    logic              arready;
    logic              arvalid;
    logic [31:0]       araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              rready;
    logic              rvalid;
    logic [1:0]        rresp;
    logic [DATA_W-1:0] rdata;
    logic              rlast;
    logic [3:0]        rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bresp, bid,
        input  arready, rvalid, rresp, rdata, rlast, rid
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rresp, rdata, rlast, rid
    );
endinterface

// File: rtl/ysyx_040066_axi_slave_addr.sv
// Window decode, error classification and beat-address generation, shared by
// the read and write paths; the burst context is captured when load is high.
module ysyx_040066_axi_slave_addr
    import ysyx_040066_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          ADDR_W    = 12
) (
    input  logic              clock,
    input  logic              load,
    input  logic              adv,
    input  logic [31:0]       addr_in,
    input  logic [2:0]        size_in,
    input  logic [1:0]        burst_in,
    output logic [1:0]        cls_in,
    output logic [1:0]        cls,
    output logic [ADDR_W-4:0] mem_idx
);
    logic [31:0]       off_in;
    logic [ADDR_W-1:0] off_q;
    logic [ADDR_W-1:0] step;
    logic [2:0]        size_q;
    logic              incr_q;

    function automatic logic [1:0] classify(input logic [31:0] off, input logic [2:0] size,
                                            input logic [1:0] burst);
        if (off[31:ADDR_W] != '0)
            return RESP_DECERR;
        if (size > 3'd3 || burst == BURST_WRAP || burst == 2'b11)
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    // Addresses below BASE_ADDR underflow to a huge offset, so one compare covers both bounds.
    assign off_in  = addr_in - BASE_ADDR;
    assign cls_in  = classify(off_in, size_in, burst_in);
    assign step    = ADDR_W'(1) << size_q;
    assign mem_idx = off_q[ADDR_W-1:3];

    // Only the in-window offset is kept, so INCR wraps silently inside the window.
    always_ff @(posedge clock) begin
        if (load) begin
            off_q  <= off_in[ADDR_W-1:0];
            size_q <= size_in;
            incr_q <= (burst_in == BURST_INCR);
            cls    <= cls_in;
        end else if (adv && incr_q) begin
            off_q <= off_q + step;
        end
    end
endmodule

// File: rtl/ysyx_040066_axi_slave.sv
// AXI4 responder serving one burst at a time from a single-port 64-bit RAM.
// Define YSYX_040066_AXI_SLAVE_TRACE_EN for simulation-only grant/response tracing.
module ysyx_040066_axi_slave
    import ysyx_040066_axi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          ADDR_W    = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    ysyx_040066_axi_slave_if.slave   io_slave,
    output logic                     mem_en,
    output logic                     mem_wen,
    output logic [ADDR_W-4:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [STRB_W-1:0]        mem_wmask,
    input  logic [DATA_W-1:0]        mem_rdata
);
    state_t            state, state_nxt;
    logic              prio_rd;
    logic [3:0]        id_q;
    logic [7:0]        len_q, cnt_q;
    logic              wr_err;
    logic [DATA_W-1:0] rdata_q;
    logic              ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic              last_beat, load, adv, cls_ok;
    logic [1:0]        cls_in, cls;

    assign ar_hs     = io_slave.arvalid & io_slave.arready;
    assign aw_hs     = io_slave.awvalid & io_slave.awready;
    assign r_hs      = io_slave.rvalid & io_slave.rready;
    assign w_hs      = io_slave.wvalid & io_slave.wready;
    assign b_hs      = io_slave.bvalid & io_slave.bready;
    assign last_beat = (cnt_q == len_q);
    assign load      = ar_hs | aw_hs;
    assign adv       = (r_hs & ~last_beat) | w_hs;
    assign cls_ok    = (cls == RESP_OKAY);

    ysyx_040066_axi_slave_addr #(.BASE_ADDR(BASE_ADDR), .ADDR_W(ADDR_W)) u_addr (
        .clock    (clock),
        .load     (load),
        .adv      (adv),
        .addr_in  (ar_hs ? io_slave.araddr  : io_slave.awaddr),
        .size_in  (ar_hs ? io_slave.arsize  : io_slave.awsize),
        .burst_in (ar_hs ? io_slave.arburst : io_slave.awburst),
        .cls_in   (cls_in),
        .cls      (cls),
        .mem_idx  (mem_addr)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (ar_hs)      state_nxt = (cls_in == RESP_OKAY) ? RD_MEM : RD_DATA;
                else if (aw_hs) state_nxt = WR_DATA;
            end
            RD_MEM:  state_nxt = RD_CAP;
            RD_CAP:  state_nxt = RD_DATA;
            RD_DATA: if (r_hs) state_nxt = last_beat ? IDLE : (cls_ok ? RD_MEM : RD_DATA);
            WR_DATA: if (w_hs && last_beat) state_nxt = WR_RESP;
            WR_RESP: if (b_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Readies are gated by reset so a held-low reset never grants a burst.
    always_comb begin
        io_slave.arready = 1'b0;
        io_slave.awready = 1'b0;
        io_slave.wready  = 1'b0;
        io_slave.rvalid  = 1'b0;
        io_slave.rresp   = RESP_OKAY;
        io_slave.rlast   = 1'b0;
        io_slave.rdata   = '0;
        io_slave.bvalid  = 1'b0;
        io_slave.bresp   = RESP_OKAY;
        mem_en           = 1'b0;
        mem_wen          = 1'b0;
        unique case (state)
            IDLE: begin
                io_slave.arready = reset & io_slave.arvalid & (~io_slave.awvalid | prio_rd);
                io_slave.awready = reset & io_slave.awvalid & (~io_slave.arvalid | ~prio_rd);
            end
            RD_MEM: mem_en = cls_ok;
            RD_CAP: ;
            RD_DATA: begin
                io_slave.rvalid = 1'b1;
                io_slave.rresp  = cls;
                io_slave.rlast  = last_beat;
                io_slave.rdata  = cls_ok ? rdata_q : '0;
            end
            WR_DATA: begin
                io_slave.wready = 1'b1;
                mem_en          = io_slave.wvalid & cls_ok;
                mem_wen         = 1'b1;
            end
            WR_RESP: begin
                io_slave.bvalid = 1'b1;
                io_slave.bresp  = cls | {wr_err, 1'b0};
            end
            default: ;
        endcase
    end

    assign io_slave.rid = id_q;
    assign io_slave.bid = id_q;
    assign mem_wdata    = io_slave.wdata;
    assign mem_wmask    = io_slave.wstrb;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio_rd <= 1'b1;
            cnt_q   <= '0;
            wr_err  <= 1'b0;
        end else begin
            if (ar_hs)      prio_rd <= 1'b0;
            else if (aw_hs) prio_rd <= 1'b1;
            if (load)     cnt_q <= '0;
            else if (adv) cnt_q <= cnt_q + 8'd1;
            if (load)                                      wr_err <= 1'b0;
            else if (w_hs && (io_slave.wlast != last_beat)) wr_err <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (load) begin
            id_q  <= ar_hs ? io_slave.arid  : io_slave.awid;
            len_q <= ar_hs ? io_slave.arlen : io_slave.awlen;
        end
        if (state == RD_CAP) rdata_q <= mem_rdata;
    end

`ifdef YSYX_040066_AXI_SLAVE_TRACE_EN
    always @(posedge clock) begin
        if (reset) begin
            if ($isunknown({io_slave.arvalid, io_slave.awvalid, io_slave.wvalid}))
                $display("axi_slave: X on valid ar=%b aw=%b w=%b",
                         io_slave.arvalid, io_slave.awvalid, io_slave.wvalid);
            if (ar_hs)
                $display("axi_slave: AR id=%0d addr=%h len=%0d size=%0d class=%0d",
                         io_slave.arid, io_slave.araddr, io_slave.arlen, io_slave.arsize, cls_in);
            if (aw_hs)
                $display("axi_slave: AW id=%0d addr=%h len=%0d size=%0d class=%0d",
                         io_slave.awid, io_slave.awaddr, io_slave.awlen, io_slave.awsize, cls_in);
            if (r_hs && io_slave.rlast)
                $display("axi_slave: R last id=%0d resp=%0d", io_slave.rid, io_slave.rresp);
            if (b_hs)
                $display("axi_slave: B id=%0d resp=%0d", io_slave.bid, io_slave.bresp);
        end
    end
`endif
endmodule

// File: tb/tb_ysyx_040066_axi_slave.sv
// Randomised bench for the io_slave AXI4 responder against a word-array memory model.
module tb_ysyx_040066_axi_slave;
    import ysyx_040066_axi_pkg::*;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam int          NW   = 512;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_en, mem_wen;
    logic [8:0]  mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    ysyx_040066_axi_slave_if bus();

    ysyx_040066_axi_slave dut (
        .clock     (clock),
        .reset     (reset),
        .io_slave  (bus),
        .mem_en    (mem_en),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          failures = 0;
    int          mem_cnt = 0;
    logic [63:0] ram [NW];
    logic [63:0] ref_mem [NW];
    logic [63:0] tmp_w;
    logic        log_wen [$];
    logic [8:0]  log_idx [$];
    logic [7:0]  log_mask [$];
    logic [63:0] rd_data [$];
    logic [1:0]  rd_resp [$];
    logic [3:0]  rd_id [$];
    logic        rd_last [$];
    logic [63:0] wbuf_data [8];
    logic [7:0]  wbuf_strb [8];
    logic        wbuf_last [8];

    // Environment RAM: one-cycle read latency, byte-masked writes.
    always @(posedge clock) begin
        if (mem_en) begin
            mem_cnt++;
            log_wen.push_back(mem_wen);
            log_idx.push_back(mem_addr);
            log_mask.push_back(mem_wmask);
            if (mem_wen) begin
                tmp_w = ram[mem_addr];
                for (int b = 0; b < 8; b++)
                    if (mem_wmask[b]) tmp_w[8*b +: 8] = mem_wdata[8*b +: 8];
                ram[mem_addr] <= tmp_w;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    function automatic int widx(input logic [31:0] a, input int beat, input int size, input logic [1:0] burst);
        logic [31:0] off;
        off = a - BASE;
        if (burst == BURST_INCR) off = off + (beat << size);
        return int'((off & 32'hFFF) >> 3);
    endfunction

    function automatic void ref_write(input int idx, input logic [63:0] d, input logic [7:0] m);
        for (int b = 0; b < 8; b++)
            if (m[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        log_wen.delete(); log_idx.delete(); log_mask.delete();
        rd_data.delete(); rd_resp.delete(); rd_id.delete(); rd_last.delete();
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bus.araddr = a; bus.arid = id; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
        bus.arvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.arready) begin
                @(posedge clock); #1;
                bus.arvalid = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        bus.arvalid = 1'b0;
        checks++; failures++;
        $display("FAIL ar_timeout arready=0 required 1");
    endtask

    task automatic send_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bus.awaddr = a; bus.awid = id; bus.awlen = len; bus.awsize = size; bus.awburst = burst;
        bus.awvalid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (bus.awready) begin
                @(posedge clock); #1;
                bus.awvalid = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        bus.awvalid = 1'b0;
        checks++; failures++;
        $display("FAIL aw_timeout awready=0 required 1");
    endtask

    task automatic send_w(input int n, input bit gaps);
        bit done;
        for (int b = 0; b < n; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            bus.wdata = wbuf_data[b]; bus.wstrb = wbuf_strb[b]; bus.wlast = wbuf_last[b];
            bus.wvalid = 1'b1;
            done = 1'b0;
            for (int i = 0; i < 100 && !done; i++) begin
                #1;
                if (bus.wready) done = 1'b1;
                @(posedge clock); #1;
            end
            bus.wvalid = 1'b0;
            if (!done) begin
                checks++; failures++;
                $display("FAIL w_timeout beat=%0d wready=0 required 1", b);
                return;
            end
        end
    endtask

    task automatic recv_r(input int n, input bit stall);
        int          got;
        bit          have_held;
        logic [63:0] held;
        got = 0; have_held = 1'b0; held = '0;
        for (int i = 0; i < 400 && got < n; i++) begin
            bus.rready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (bus.rvalid) begin
                if (have_held) begin
                    checks++;
                    if (bus.rdata !== held) begin
                        failures++;
                        $display("FAIL rdata_stable got=%h required=%h", bus.rdata, held);
                    end
                end
                if (bus.rready) begin
                    rd_data.push_back(bus.rdata); rd_resp.push_back(bus.rresp);
                    rd_id.push_back(bus.rid);     rd_last.push_back(bus.rlast);
                    got++; have_held = 1'b0;
                end else begin
                    held = bus.rdata; have_held = 1'b1;
                end
            end
            @(posedge clock); #1;
        end
        bus.rready = 1'b0;
        if (got < n) begin
            checks++; failures++;
            $display("FAIL r_timeout beats=%0d required=%0d", got, n);
        end
    endtask

    task automatic recv_b(input bit stall, output logic [1:0] resp, output logic [3:0] id);
        resp = 2'bxx; id = 4'bxxxx;
        for (int i = 0; i < 100; i++) begin
            bus.bready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (bus.bvalid && bus.bready) begin
                resp = bus.bresp; id = bus.bid;
                @(posedge clock); #1;
                bus.bready = 1'b0;
                return;
            end
            @(posedge clock); #1;
        end
        bus.bready = 1'b0;
        checks++; failures++;
        $display("FAIL b_timeout bvalid never accepted");
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.arvalid = 1'b1; bus.awvalid = 1'b1;
        repeat (3) tick();
        checks++; if (bus.arready !== 1'b0) begin failures++; $display("FAIL reset_arready got=%b required=0", bus.arready); end
        checks++; if (bus.awready !== 1'b0) begin failures++; $display("FAIL reset_awready got=%b required=0", bus.awready); end
        checks++; if (bus.wready !== 1'b0) begin failures++; $display("FAIL reset_wready got=%b required=0", bus.wready); end
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b required=0", bus.rvalid); end
        checks++; if (bus.bvalid !== 1'b0) begin failures++; $display("FAIL reset_bvalid got=%b required=0", bus.bvalid); end
        checks++; if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en got=%b required=0", mem_en); end
        checks++; if ({bus.rresp, bus.bresp, bus.rlast} !== 5'b0) begin
            failures++; $display("FAIL reset_resp got=%b required=00000", {bus.rresp, bus.bresp, bus.rlast});
        end
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        int c0;
        clear_logs();
        ram[2] = 64'hDEAD_BEEF_0123_4567; ref_mem[2] = 64'hDEAD_BEEF_0123_4567;
        c0 = mem_cnt;
        send_ar(32'h1000_0010, 4'd5, 8'd0, 3'd3, BURST_INCR);
        // The first R handshake is possible at the third rising edge after the AR handshake edge.
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL lat_edge0 rvalid=%b required=0", bus.rvalid); end
        tick();
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL lat_edge1 rvalid=%b required=0", bus.rvalid); end
        tick();
        checks++; if (bus.rvalid !== 1'b1) begin failures++; $display("FAIL lat_edge2 rvalid=%b required=1", bus.rvalid); end
        recv_r(1, 1'b0);
        if (rd_data.size() == 1) begin
            checks++; if (rd_data[0] !== 64'hDEAD_BEEF_0123_4567) begin failures++; $display("FAIL single_rdata got=%h required=deadbeef01234567", rd_data[0]); end
            checks++; if ({rd_id[0], rd_resp[0], rd_last[0]} !== {4'd5, 2'd0, 1'b1}) begin
                failures++; $display("FAIL single_rid_rresp_rlast got=%0d/%0d/%0d required=5/0/1", rd_id[0], rd_resp[0], rd_last[0]);
            end
        end
        checks++; if (mem_cnt - c0 !== 1) begin failures++; $display("FAIL single_mem_accesses got=%0d required=1", mem_cnt - c0); end
    endtask

    task automatic test_incr_write();
        logic [1:0] bresp;
        logic [3:0] bid, wid, rid;
        wid = 4'($urandom); rid = 4'($urandom);
        for (int i = 0; i < 8; i++) begin
            wbuf_data[i] = {$urandom, $urandom}; wbuf_strb[i] = 8'hFF; wbuf_last[i] = (i == 7);
        end
        clear_logs();
        send_aw(BASE, wid, 8'd7, 3'd3, BURST_INCR);
        send_w(8, 1'b1);
        recv_b(1'b1, bresp, bid);
        checks++; if (log_idx.size() != 8) begin failures++; $display("FAIL incr_wr_count got=%0d required=8", log_idx.size()); end
        for (int i = 0; i < 8 && i < log_idx.size(); i++) begin
            checks++;
            if ({log_wen[i], log_idx[i], log_mask[i]} !== {1'b1, 9'(i), 8'hFF}) begin
                failures++; $display("FAIL incr_wr_beat%0d wen/idx/mask got=%b/%0d/%h required=1/%0d/ff", i, log_wen[i], log_idx[i], log_mask[i], i);
            end
        end
        checks++; if ({bresp, bid} !== {2'd0, wid}) begin failures++; $display("FAIL incr_wr_b resp/id got=%0d/%0d required=0/%0d", bresp, bid, wid); end
        for (int i = 0; i < 8; i++) ref_write(widx(BASE, i, 3, BURST_INCR), wbuf_data[i], 8'hFF);
        clear_logs();
        send_ar(BASE, rid, 8'd7, 3'd3, BURST_INCR);
        recv_r(8, 1'b1);
        for (int i = 0; i < 8 && i < rd_data.size(); i++) begin
            checks++;
            if ({rd_data[i], rd_resp[i], rd_id[i], rd_last[i]} !== {wbuf_data[i], 2'd0, rid, (i == 7)}) begin
                failures++; $display("FAIL readback_beat%0d data/resp/id/last got=%h/%0d/%0d/%0d required=%h/0/%0d/%0d", i, rd_data[i], rd_resp[i], rd_id[i], rd_last[i], wbuf_data[i], rid, (i == 7));
            end
        end
    endtask

    task automatic test_narrow_write();
        logic [1:0] bresp;
        logic [3:0] bid;
        wbuf_data[0] = {$urandom, $urandom}; wbuf_strb[0] = 8'hF0; wbuf_last[0] = 1'b1;
        clear_logs();
        send_aw(BASE + 32'h4, 4'd2, 8'd0, 3'd2, BURST_INCR);
        send_w(1, 1'b0);
        recv_b(1'b0, bresp, bid);
        checks++; if (log_idx.size() != 1) begin failures++; $display("FAIL narrow_count got=%0d required=1", log_idx.size()); end
        if (log_idx.size() >= 1) begin
            checks++; if ({log_wen[0], log_idx[0], log_mask[0]} !== {1'b1, 9'd0, 8'hF0}) begin
                failures++; $display("FAIL narrow_access wen/idx/mask got=%b/%0d/%h required=1/0/f0", log_wen[0], log_idx[0], log_mask[0]);
            end
        end
        checks++; if (bresp !== 2'd0) begin failures++; $display("FAIL narrow_bresp got=%0d required=0", bresp); end
        ref_write(widx(BASE + 32'h4, 0, 2, BURST_INCR), wbuf_data[0], 8'hF0);
        clear_logs();
        send_ar(BASE, 4'd1, 8'd0, 3'd3, BURST_INCR);
        recv_r(1, 1'b0);
        if (rd_data.size() == 1) begin
            checks++; if (rd_data[0] !== ref_mem[0]) begin failures++; $display("FAIL narrow_readback got=%h required=%h", rd_data[0], ref_mem[0]); end
        end
    endtask

    task automatic test_oor_read();
        int c0;
        clear_logs();
        c0 = mem_cnt;
        send_ar(32'h2000_0000, 4'd6, 8'd3, 3'd3, BURST_INCR);
        recv_r(4, 1'b1);
        checks++; if (rd_data.size() != 4) begin failures++; $display("FAIL oor_beats got=%0d required=4", rd_data.size()); end
        for (int i = 0; i < 4 && i < rd_data.size(); i++) begin
            checks++;
            if ({rd_data[i], rd_resp[i], rd_last[i]} !== {64'd0, RESP_DECERR, (i == 3)}) begin
                failures++; $display("FAIL oor_beat%0d data/resp/last got=%h/%0d/%0d required=0/3/%0d", i, rd_data[i], rd_resp[i], rd_last[i], (i == 3));
            end
        end
        checks++; if (mem_cnt != c0) begin failures++; $display("FAIL oor_mem_en accesses=%0d required=0", mem_cnt - c0); end
    endtask

    task automatic test_wlast_early();
        logic [1:0] bresp;
        logic [3:0] bid;
        for (int i = 0; i < 4; i++) begin
            wbuf_data[i] = {$urandom, $urandom}; wbuf_strb[i] = 8'($urandom); wbuf_last[i] = (i == 2);
        end
        clear_logs();
        send_aw(BASE + 32'h100, 4'd4, 8'd3, 3'd3, BURST_INCR);
        send_w(4, 1'b1);
        recv_b(1'b1, bresp, bid);
        checks++; if (log_idx.size() != 4) begin failures++; $display("FAIL wlast_beats got=%0d required=4", log_idx.size()); end
        checks++; if ({bresp, bid} !== {RESP_SLVERR, 4'd4}) begin failures++; $display("FAIL wlast_b resp/id got=%0d/%0d required=2/4", bresp, bid); end
        for (int i = 0; i < 4; i++) ref_write(widx(BASE + 32'h100, i, 3, BURST_INCR), wbuf_data[i], wbuf_strb[i]);
    endtask

    task automatic test_simultaneous();
        logic [1:0] bresp;
        logic [3:0] bid;
        reset = 1'b0; tick(); reset = 1'b1; tick();
        clear_logs();
        bus.araddr = BASE + 32'h100; bus.arid = 4'd3; bus.arlen = 8'd0; bus.arsize = 3'd3; bus.arburst = BURST_INCR;
        bus.awaddr = BASE + 32'h200; bus.awid = 4'd9; bus.awlen = 8'd0; bus.awsize = 3'd3; bus.awburst = BURST_INCR;
        bus.arvalid = 1'b1; bus.awvalid = 1'b1;
        #1;
        checks++; if ({bus.arready, bus.awready} !== 2'b10) begin
            failures++; $display("FAIL both_valid_grant ar/aw ready got=%b required=10", {bus.arready, bus.awready});
        end
        @(posedge clock); #1;
        bus.arvalid = 1'b0;
        #1;
        checks++; if (bus.awready !== 1'b0) begin failures++; $display("FAIL aw_wait_in_read awready=%b required=0", bus.awready); end
        recv_r(1, 1'b0);
        if (rd_data.size() == 1) begin
            checks++; if ({rd_data[0], rd_id[0]} !== {ref_mem[32], 4'd3}) begin
                failures++; $display("FAIL both_read data/id got=%h/%0d required=%h/3", rd_data[0], rd_id[0], ref_mem[32]);
            end
        end
        #1;
        checks++; if (bus.awready !== 1'b1) begin failures++; $display("FAIL aw_after_read awready=%b required=1", bus.awready); end
        wbuf_data[0] = {$urandom, $urandom}; wbuf_strb[0] = 8'hFF; wbuf_last[0] = 1'b1;
        send_aw(BASE + 32'h200, 4'd9, 8'd0, 3'd3, BURST_INCR);
        send_w(1, 1'b0);
        recv_b(1'b0, bresp, bid);
        checks++; if ({bresp, bid} !== {2'd0, 4'd9}) begin failures++; $display("FAIL both_write_b resp/id got=%0d/%0d required=0/9", bresp, bid); end
        ref_write(64, wbuf_data[0], 8'hFF);
    endtask

    task automatic test_mid_reset();
        bit seen;
        send_ar(BASE + 32'h40, 4'd7, 8'd3, 3'd3, BURST_INCR);
        bus.rready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (bus.rvalid) seen = 1'b1;
            else begin @(posedge clock); #1; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL midrst_rvalid rvalid=0 required=1"); end
        bus.arvalid = 1'b1; bus.awvalid = 1'b1;
        #1 reset = 1'b0;
        #1;
        checks++; if ({bus.rvalid, bus.awready, bus.arready, mem_en} !== 4'b0) begin
            failures++; $display("FAIL midrst_outputs rvalid/awready/arready/mem_en got=%b required=0000", {bus.rvalid, bus.awready, bus.arready, mem_en});
        end
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0;
        reset = 1'b1;
        tick();
        clear_logs();
        send_ar(BASE + 32'h40, 4'd8, 8'd0, 3'd3, BURST_INCR);
        recv_r(1, 1'b0);
        if (rd_data.size() == 1) begin
            checks++; if ({rd_data[0], rd_id[0], rd_resp[0], rd_last[0]} !== {ref_mem[8], 4'd8, 2'd0, 1'b1}) begin
                failures++; $display("FAIL midrst_fresh_read data/id/resp/last got=%h/%0d/%0d/%0d required=%h/8/0/1", rd_data[0], rd_id[0], rd_resp[0], rd_last[0], ref_mem[8]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [7:0]  len;
        logic [1:0]  burst, bresp;
        logic [3:0]  id, bid;
        for (int t = 0; t < 8; t++) begin
            a = BASE + ($urandom_range(0, NW - 1) << 3);
            len = 8'($urandom_range(0, 7));
            burst = $urandom_range(0, 1) ? BURST_INCR : BURST_FIXED;
            id = 4'($urandom);
            clear_logs();
            if ($urandom_range(0, 1)) begin
                for (int i = 0; i <= int'(len); i++) begin
                    wbuf_data[i] = {$urandom, $urandom}; wbuf_strb[i] = 8'($urandom); wbuf_last[i] = (i == int'(len));
                end
                send_aw(a, id, len, 3'd3, burst);
                send_w(int'(len) + 1, 1'b1);
                recv_b(1'b1, bresp, bid);
                checks++; if ({bresp, bid} !== {2'd0, id}) begin failures++; $display("FAIL rand%0d_b resp/id got=%0d/%0d required=0/%0d", t, bresp, bid, id); end
                for (int i = 0; i <= int'(len); i++) begin
                    if (i < log_idx.size()) begin
                        checks++;
                        if (log_idx[i] !== 9'(widx(a, i, 3, burst))) begin
                            failures++; $display("FAIL rand%0d_widx%0d got=%0d required=%0d", t, i, log_idx[i], widx(a, i, 3, burst));
                        end
                    end
                    ref_write(widx(a, i, 3, burst), wbuf_data[i], wbuf_strb[i]);
                end
            end else begin
                send_ar(a, id, len, 3'd3, burst);
                recv_r(int'(len) + 1, 1'b1);
                for (int i = 0; i < rd_data.size(); i++) begin
                    checks++;
                    if ({rd_data[i], rd_id[i], rd_last[i]} !== {ref_mem[widx(a, i, 3, burst)], id, (i == int'(len))}) begin
                        failures++; $display("FAIL rand%0d_rbeat%0d data/id/last got=%h/%0d/%0d required=%h/%0d/%0d", t, i, rd_data[i], rd_id[i], rd_last[i], ref_mem[widx(a, i, 3, burst)], id, (i == int'(len)));
                    end
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NW; i++) begin
            ram[i] = {$urandom, $urandom};
            ref_mem[i] = ram[i];
        end
        mem_rdata = '0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arid = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awid = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.rready = 1'b0; bus.bready = 1'b0;
        #1;
        test_reset();
        test_single_read();
        test_incr_write();
        test_narrow_write();
        test_oor_read();
        test_wlast_early();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
